sseg_avalon_ctrl: RTL and testbench

Parametrised seven-segment display controller, an Avalon-MM slave on the Nios II system bus. It drives N_DIGITS active-low seven-segment digits and replaces the raw 32-bit PIO used for segment patterns until now. Features: hardware hex decode, per-digit raw-segment override, blanking, blinking, and shadow/active double buffering so multi-digit updates appear at once.

---
 rtl/sseg_avalon_ctrl_if.sv | 24 ++
 rtl/sseg_avalon_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sseg_avalon_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sseg_avalon_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sseg_avalon_if : Avalon-MM slave port bundle for sseg_avalon_ctrl  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface sseg_avalon_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata, read,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/sseg_avalon_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sseg_avalon_ctrl : double-buffered seven-segment display controller|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sseg_avalon_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  sseg_avalon_if.slave                 bus,
  output logic [7*N_DIGITS-1:0]        hex_n
);

  localparam int               CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLINK_DIV - 1);
  localparam logic [3:0]       ADDR_CTRL = 4'd0;
  localparam logic [3:0]       ADDR_HEX  = 4'd1;
  localparam int               ADDR_RAW0 = 2;
  localparam logic [6:0]       SEG_DARK  = 7'h7F;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  logic [N_DIGITS-1:0]   blank_q, blank_d;
  logic [N_DIGITS-1:0]   blink_q, blink_d;
  logic                  enable_q, enable_d;
  logic                  auto_q, auto_d;
  logic [4*N_DIGITS-1:0] hex_sh_q, hex_sh_d;
  logic [4*N_DIGITS-1:0] hex_act_q, hex_act_d;
  logic [7:0]            raw_sh_q  [N_DIGITS];
  logic [7:0]            raw_sh_d  [N_DIGITS];
  logic [7:0]            raw_act_q [N_DIGITS];
  logic [7:0]            raw_act_d [N_DIGITS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [7*N_DIGITS-1:0] hex_n_q, hex_n_d;

  logic        w_wr;
  logic        w_rd;
  logic        w_wrap;
  logic [31:0] w_rd_mux;

  assign w_wr   = bus.chipselect & bus.write;
  assign w_rd   = bus.chipselect & bus.read;
  assign w_wrap = (cnt_q == CNT_MAX);

  assign bus.readdata = readdata_q;
  assign hex_n        = hex_n_q;

  // Register writes: shadow always, active on auto_commit or on a CTRL commit.
  always_comb begin
    blank_d   = blank_q;
    blink_d   = blink_q;
    enable_d  = enable_q;
    auto_d    = auto_q;
    hex_sh_d  = hex_sh_q;
    hex_act_d = hex_act_q;
    raw_sh_d  = raw_sh_q;
    raw_act_d = raw_act_q;
    if (w_wr && bus.address == ADDR_CTRL) begin
      blank_d  = bus.writedata[N_DIGITS-1:0];
      blink_d  = bus.writedata[8 +: N_DIGITS];
      enable_d = bus.writedata[16];
      auto_d   = bus.writedata[17];
      if (bus.writedata[31]) begin
        hex_act_d = hex_sh_q;
        raw_act_d = raw_sh_q;
      end
    end
    if (w_wr && bus.address == ADDR_HEX) begin
      hex_sh_d = bus.writedata[4*N_DIGITS-1:0];
      if (auto_q) hex_act_d = bus.writedata[4*N_DIGITS-1:0];
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_wr && bus.address == 4'(ADDR_RAW0 + k)) begin
        raw_sh_d[k] = bus.writedata[7:0];
        if (auto_q) raw_act_d[k] = bus.writedata[7:0];
      end
    end
  end

  // Free-running blink divider.
  always_comb begin
    cnt_d   = w_wrap ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ w_wrap;
  end

  // Reads always see the shadow copy, sampled before any same-cycle write.
  always_comb begin
    w_rd_mux = '0;
    if (bus.address == ADDR_CTRL) begin
      w_rd_mux[N_DIGITS-1:0]   = blank_q;
      w_rd_mux[8 +: N_DIGITS]  = blink_q;
      w_rd_mux[16]             = enable_q;
      w_rd_mux[17]             = auto_q;
    end else if (bus.address == ADDR_HEX) begin
      w_rd_mux[4*N_DIGITS-1:0] = hex_sh_q;
    end else begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (bus.address == 4'(ADDR_RAW0 + k)) w_rd_mux[7:0] = raw_sh_q[k];
      end
    end
    readdata_d = w_rd ? w_rd_mux : readdata_q;
  end

  always_comb begin
    hex_n_d = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!enable_q || blank_q[k]) begin
        hex_n_d[7*k +: 7] = SEG_DARK;
      end else if (blink_q[k] && phase_q) begin
        hex_n_d[7*k +: 7] = SEG_DARK;
      end else if (raw_act_q[k][7]) begin
        hex_n_d[7*k +: 7] = ~raw_act_q[k][6:0];
      end else begin
        hex_n_d[7*k +: 7] = hex_decode(hex_act_q[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q    <= '0;
      blink_q    <= '0;
      enable_q   <= 1'b0;
      auto_q     <= 1'b1;
      hex_sh_q   <= '0;
      hex_act_q  <= '0;
      for (int k = 0; k < N_DIGITS; k++) begin
        raw_sh_q[k]  <= '0;
        raw_act_q[k] <= '0;
      end
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
      hex_n_q    <= '1;
    end else begin
      blank_q    <= blank_d;
      blink_q    <= blink_d;
      enable_q   <= enable_d;
      auto_q     <= auto_d;
      hex_sh_q   <= hex_sh_d;
      hex_act_q  <= hex_act_d;
      raw_sh_q   <= raw_sh_d;
      raw_act_q  <= raw_act_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
      hex_n_q    <= hex_n_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_avalon_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sseg_avalon_ctrl : directed bench, 4-digit and 2-digit instances|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sseg_avalon_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sseg_avalon_if bus4();
  sseg_avalon_if bus2();
  logic [27:0] hex4;
  logic [13:0] hex2;

  sseg_avalon_ctrl #(.N_DIGITS(4), .BLINK_DIV(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4), .hex_n(hex4)
  );
  sseg_avalon_ctrl #(.N_DIGITS(2), .BLINK_DIV(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .hex_n(hex2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [6:0] d3, d2, d1, d0);
    return {4'b0, d3, d2, d1, d0};
  endfunction

  task automatic bus_set(input bit sel, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [31:0] d);
    if (sel) begin
      bus2.chipselect = rd | wr; bus2.read = rd; bus2.write = wr;
      bus2.address = a; bus2.writedata = d;
    end else begin
      bus4.chipselect = rd | wr; bus4.read = rd; bus4.write = wr;
      bus4.address = a; bus4.writedata = d;
    end
  endtask

  task automatic bus_wr(input bit sel, input logic [3:0] a, input logic [31:0] d);
    bus_set(sel, 1'b0, 1'b1, a, d);
    @(negedge clk);
    bus_set(sel, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic bus_rd(input bit sel, input logic [3:0] a, output logic [31:0] d);
    bus_set(sel, 1'b1, 1'b0, a, 32'd0);
    @(negedge clk);
    bus_set(sel, 1'b0, 1'b0, 4'd0, 32'd0);
    d = sel ? bus2.readdata : bus4.readdata;
  endtask

  // Called at the negedge after edge 1 following reset release with CTRL=0x0003_0201.
  task automatic check_blink(input string tag);
    logic [6:0] d1;
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      d1 = ((((k - 1) / 4) % 2) != 0) ? 7'h7F : 7'h40;
      check($sformatf("%s_e%0d", tag, k), 32'(hex4), pack4(7'h40, 7'h40, d1, 7'h7F));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bus_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    bus_set(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);

    repeat (3) @(negedge clk);
    check("reset_hex4", 32'(hex4), 32'h0FFF_FFFF);
    check("reset_rd4", bus4.readdata, 32'd0);
    check("reset_hex2", 32'(hex2), 32'h0000_3FFF);

    // Release reset and issue first accesses so they land on edge 1.
    reset_n = 1'b1;
    bus_set(1'b0, 1'b0, 1'b1, 4'd0, 32'h0003_0201);
    bus_set(1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    bus_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    bus_set(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    check("reset_ctrl_read", bus2.readdata, 32'h0002_0000);
    check("blink_e1", 32'(hex4), 32'h0FFF_FFFF);
    check_blink("blink");

    // Decode sweep through a manual commit.
    bus_wr(1'b0, 4'd0, 32'h0001_0000);
    @(negedge clk);
    check("no_auto_ctrl", 32'(hex4), pack4(7'h40, 7'h40, 7'h40, 7'h40));
    bus_wr(1'b0, 4'd1, 32'h0000_FEDC);
    @(negedge clk);
    check("shadow_only", 32'(hex4), pack4(7'h40, 7'h40, 7'h40, 7'h40));
    bus_rd(1'b0, 4'd1, rd);
    check("shadow_read", rd, 32'h0000_FEDC);
    bus_wr(1'b0, 4'd0, 32'h8001_0000);
    check("pre_commit", 32'(hex4), pack4(7'h40, 7'h40, 7'h40, 7'h40));
    @(negedge clk);
    check("commit", 32'(hex4), pack4(7'h0E, 7'h06, 7'h21, 7'h46));

    // Auto commit and raw override.
    bus_wr(1'b0, 4'd0, 32'h0003_0000);
    bus_wr(1'b0, 4'd1, 32'h0000_1234);
    @(negedge clk);
    check("auto_hex", 32'(hex4), pack4(7'h79, 7'h24, 7'h30, 7'h19));
    bus_wr(1'b0, 4'd3, 32'h0000_00C9);
    @(negedge clk);
    check("raw_override", 32'(hex4), pack4(7'h79, 7'h24, 7'h36, 7'h19));
    bus_rd(1'b0, 4'd3, rd);
    check("raw_read", rd, 32'h0000_00C9);
    bus_wr(1'b0, 4'd0, 32'h8003_0000);
    bus_rd(1'b0, 4'd0, rd);
    check("ctrl_read_commit0", rd, 32'h0003_0000);
    check("commit_harmless", 32'(hex4), pack4(7'h79, 7'h24, 7'h36, 7'h19));

    // Simultaneous read and write returns the pre-write value.
    bus_set(1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_AAAA);
    @(negedge clk);
    bus_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    check("rdwr_old", bus4.readdata, 32'h0000_1234);
    bus_rd(1'b0, 4'd1, rd);
    check("rdwr_new", rd, 32'h0000_AAAA);
    check("rdwr_hex", 32'(hex4), pack4(7'h08, 7'h08, 7'h36, 7'h08));

    // Two-digit boundaries.
    bus_wr(1'b1, 4'd0, 32'h0003_0000);
    bus_wr(1'b1, 4'd4, 32'hFFFF_FFFF);
    @(negedge clk);
    check("unmapped_wr_hex", 32'(hex2), pack4(7'h00, 7'h00, 7'h40, 7'h40));
    bus_rd(1'b1, 4'd4, rd);
    check("unmapped_rd", rd, 32'd0);
    bus_wr(1'b1, 4'd1, 32'hFFFF_FFFF);
    bus_rd(1'b1, 4'd1, rd);
    check("hex_trunc_rd", rd, 32'h0000_00FF);
    check("hex_trunc_disp", 32'(hex2), pack4(7'h00, 7'h00, 7'h0E, 7'h0E));
    bus_wr(1'b1, 4'd0, 32'h7FFF_FFFF);
    bus_rd(1'b1, 4'd0, rd);
    check("mask_trunc_rd", rd, 32'h0003_0303);

    // Asynchronous reset between edges, then blink restarts from zero.
    #2 reset_n = 1'b0;
    #1;
    check("midrst_hex", 32'(hex4), 32'h0FFF_FFFF);
    check("midrst_rd", bus4.readdata, 32'd0);
    #1 reset_n = 1'b1;
    bus_wr(1'b0, 4'd0, 32'h0003_0201);
    check("midrst_e1", 32'(hex4), 32'h0FFF_FFFF);
    check_blink("reblink");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
